// File: rtl/bcd_counter_display.sv
// bcd_counter_display
// Multi-digit BCD up/down counter with a clock-enable prescaler, synchronous
// load, optional saturation at the limits and a per-digit 7-segment decode.
//
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous, active-high reset
//   enable      advances the prescaler when high
//   up_down     1 = count up, 0 = count down
//   load        synchronous load strobe (highest priority)
//   load_value  BCD load value, digit 0 in bits [3:0]
//   count_bcd   registered BCD count
//   segments    active-low a..g pattern per digit (MSB = a), digit 0 in [6:0]
//   wrap        one-cycle pulse when the count wraps at a limit
//   at_limit    count sits at the limit for the current direction
//   load_err    one-cycle pulse when a load carries a nibble above 9
module bcd_counter_display #(
    parameter int DIGITS        = 2,
    parameter int MAX_COUNT     = 99,
    parameter int TICK_DIV      = 1,
    parameter int SATURATE      = 0,
    parameter int BLANK_LEADING = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  up_down,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic [7*DIGITS-1:0]   segments,
    output logic                  wrap,
    output logic                  at_limit,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;

    function automatic logic [W-1:0] to_bcd(input int value);
        logic [W-1:0] r;
        int           v;
        r = '0;
        v = value;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    localparam logic [W-1:0] MAX_BCD  = to_bcd(MAX_COUNT);
    localparam logic [15:0]  DIV_LAST = 16'(TICK_DIV - 1);

    function automatic logic bcd_valid(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    // Ripple a decimal carry from digit 0 upward.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Ripple a decimal borrow: a zero digit becomes 9 and borrows onward.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    logic [15:0] div_cnt;
    logic        tick;

    // Load holds the prescaler cleared, so a tick can only come from an
    // enabled, non-load cycle.
    assign tick = enable && !load && (div_cnt == DIV_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_bcd <= '0;
            div_cnt   <= '0;
            wrap      <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                div_cnt <= '0;
                if (!bcd_valid(load_value))
                    load_err <= 1'b1;
                else if (load_value > MAX_BCD)
                    count_bcd <= MAX_BCD;   // valid BCD orders like binary
                else
                    count_bcd <= load_value;
            end else if (enable) begin
                div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
                if (tick) begin
                    if (up_down) begin
                        if (count_bcd == MAX_BCD) begin
                            if (SATURATE == 0) begin
                                count_bcd <= '0;
                                wrap      <= 1'b1;
                            end
                        end else begin
                            count_bcd <= bcd_inc(count_bcd);
                        end
                    end else begin
                        if (count_bcd == '0) begin
                            if (SATURATE == 0) begin
                                count_bcd <= MAX_BCD;
                                wrap      <= 1'b1;
                            end
                        end else begin
                            count_bcd <= bcd_dec(count_bcd);
                        end
                    end
                end
            end
        end
    end

    assign at_limit = up_down ? (count_bcd == MAX_BCD) : (count_bcd == '0);

    // Walk from the top digit down; a digit is blanked only while it and
    // every digit above it are zero. Digit 0 always shows its value.
    always_comb begin
        logic seen;
        segments = '1;
        seen     = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (count_bcd[4*i +: 4] != 4'd0) seen = 1'b1;
            if ((BLANK_LEADING != 0) && (i != 0) && !seen)
                segments[7*i +: 7] = 7'b1111111;
            else
                segments[7*i +: 7] = seg7(count_bcd[4*i +: 4]);
        end
    end

endmodule

// File: doc/bcd_counter_display.md
BCD_COUNTER_DISPLAY -- requirements
Module: bcd_counter_display

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DIGITS, 2, number of BCD digits (1..4).
- MAX_COUNT, 99, terminal count (decimal); must be less than 10^DIGITS.
- TICK_DIV, 1, enabled clock cycles per count step (1..65535).
- SATURATE, 0, 0 = wrap at limits, 1 = hold at limits.
- BLANK_LEADING, 0, 1 = blank leading zero digits (digit 0 never blanked).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clock, in, 1, rising-edge clock.
- reset, in, 1, asynchronous, active-high reset.
- enable, in, 1, advances the prescaler when high.
- up_down, in, 1, 1 = count up, 0 = count down.
- load, in, 1, synchronous load strobe.
- load_value, in, 4*DIGITS, BCD load value; digit 0 is in bits [3:0].
- count_bcd, out, 4*DIGITS, registered BCD count.
- segments, out, 7*DIGITS, per-digit 7-segment pattern; digit 0 is in bits [6:0].
- wrap, out, 1, one-cycle pulse on a wrap event.
- at_limit, out, 1, count sits at the limit for the current direction.
- load_err, out, 1, one-cycle pulse when a load is rejected.

Function
REQ-003 Priority at each rising clock edge SHALL be load first, then tick, then hold.
REQ-004 Load SHALL be rejected if any load_value nibble exceeds 9.
- count_bcd is unchanged.
- load_err pulses on the next cycle.
- The prescaler is still cleared.
REQ-005 A valid load SHALL set count_bcd to min(load_value, MAX_COUNT) and clear the prescaler.
REQ-006 The prescaler SHALL behave as follows.
- div_cnt increments on each cycle with enable=1 and load=0.
- A tick is generated when div_cnt = TICK_DIV-1 with enable=1; div_cnt then returns to 0.
- With TICK_DIV=1, every enabled cycle is a tick.
REQ-007 enable=0 SHALL freeze both div_cnt and count_bcd.
REQ-008 Counting up on a tick SHALL add 1 with decimal carry between digits.
- At MAX_COUNT with SATURATE=0: next value is 0 and wrap=1.
- At MAX_COUNT with SATURATE=1: value holds and wrap=0.
REQ-009 Counting down on a tick SHALL subtract 1 with decimal borrow (a 0 digit becomes 9 and borrows).
- At 0 with SATURATE=0: next value is MAX_COUNT and wrap=1.
- At 0 with SATURATE=1: value holds and wrap=0.
REQ-010 count_bcd SHALL update on the same edge as the tick; latency from the qualifying edge is 0 extra cycles.
REQ-011 wrap and load_err SHALL be registered and high for exactly one cycle per event.
REQ-012 at_limit SHALL be combinational from count_bcd and up_down.
- High when count = MAX_COUNT with up_down=1.
- High when count = 0 with up_down=0.
REQ-013 A change of up_down SHALL take effect on the next tick, with no extra latency and no effect on div_cnt.
REQ-014 segments SHALL be a combinational decode of count_bcd: 7 bits a..g, MSB = a, active-low.
- Digits 0..9 decode to 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100.
- Blank decodes to 1111111.
REQ-015 With BLANK_LEADING=1, every digit above the most significant nonzero digit SHALL show blank; digit 0 always shows its value.
REQ-016 count_bcd SHALL never hold a nibble above 9 or a value above MAX_COUNT.

Reset
REQ-017 While reset=1, asynchronously:
- count_bcd = 0, div_cnt = 0.
- wrap = 0, load_err = 0.
- segments show "0" on digit 0; upper digits show "0", or blank if BLANK_LEADING=1.
REQ-018 Reset asserted mid-prescale SHALL discard the partial prescale count.
REQ-019 After reset deassertion, the first tick SHALL occur TICK_DIV enabled cycles later.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Up wrap (DIGITS=2, MAX_COUNT=99, TICK_DIV=1): count from 98 -> 99 then 00, wrap pulses once, at_limit=1 at 99.
- Down borrow: load 10, up_down=0 -> 09, segments digit 0 = 0000100, digit 1 = 0000001.
- Saturate (SATURATE=1, MAX_COUNT=59): up at 59 -> holds at 59, wrap stays 0; down at 0 -> holds at 0.
- Prescale (TICK_DIV=4): 3 enabled cycles, 2 disabled cycles, 1 enabled cycle -> count steps once, on the 4th enabled edge.
- Loads: load 0xA5 -> load_err pulse, count unchanged; load 75 with MAX_COUNT=59 -> count 59; load and enable on the same edge -> load wins.
- Reset mid-count: assert reset at count 42, div_cnt 2 -> immediate 00; with BLANK_LEADING=1, digit 1 segments = 1111111.
